// File: rtl/sar_search_8b_if.sv
// Search-controller bundle: start/status toward the host, guess/flags toward the
// magnitude comparator. master = search controller, slave = host/comparator side.
interface sar_search_8b_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] guess;
  logic             eq;
  logic             lt;
  logic             gt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] nprobes;
  logic             err;

  modport master (
    input  start, eq, lt, gt,
    output guess, busy, done, result, nprobes, err
  );

  modport slave (
    output start, eq, lt, gt,
    input  guess, busy, done, result, nprobes, err
  );
endinterface

// File: rtl/sar_search_8b.sv
// Successive-approximation search over an external comparator, MSB first.
// Optional SAR_EARLY_EXIT_EN: finish as soon as the comparator reports eq.
//
// state | meaning
// IDLE  | waiting for start, guess driven to 0
// PROBE | one bit decided per edge, busy high
// DONE  | single-cycle done pulse, guess shows result
module sar_search_8b #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  sar_search_8b_if.master bus
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] trial, trial_nx;
  logic [CNT_W-1:0] bitpos, bitpos_nx;
  logic [WIDTH-1:0] result, result_nx;
  logic [CNT_W-1:0] nprobes, nprobes_nx;
  logic             err, err_nx;

  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] probe;
  logic [WIDTH-1:0] trial_upd;
  logic             flags_legal;
  logic             set_bit;
  logic             finish;

  assign bit_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << bitpos;
  assign probe     = trial | bit_mask;
  // eq wins over gt; with no flag at all the bit is kept, same as lt
  assign set_bit   = bus.eq | ~bus.gt;
  assign trial_upd = set_bit ? probe : trial;

  assign flags_legal = ( bus.eq & ~bus.lt & ~bus.gt) |
                       (~bus.eq &  bus.lt & ~bus.gt) |
                       (~bus.eq & ~bus.lt &  bus.gt);

`ifdef SAR_EARLY_EXIT_EN
  assign finish = bus.eq | (bitpos == '0);
`else
  assign finish = (bitpos == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      trial   <= '0;
      bitpos  <= '0;
      result  <= '0;
      nprobes <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      trial   <= trial_nx;
      bitpos  <= bitpos_nx;
      result  <= result_nx;
      nprobes <= nprobes_nx;
      err     <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    trial_nx   = trial;
    bitpos_nx  = bitpos;
    result_nx  = result;
    nprobes_nx = nprobes;
    err_nx     = err;
    bus.guess  = '0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          trial_nx   = '0;
          bitpos_nx  = CNT_W'(WIDTH - 1);
          nprobes_nx = '0;
          err_nx     = 1'b0;
          state_nx   = PROBE;
        end
      end
      PROBE: begin
        bus.busy   = 1'b1;
        bus.guess  = probe;
        nprobes_nx = nprobes + CNT_W'(1);
        trial_nx   = trial_upd;
        if (!flags_legal) err_nx = 1'b1;
        if (finish) begin
          result_nx = trial_upd;
          state_nx  = DONE;
        end else begin
          bitpos_nx = bitpos - CNT_W'(1);
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        bus.guess = result;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.result  = result;
  assign bus.nprobes = nprobes;
  assign bus.err     = err;

endmodule

// File: doc/sar_search_8b.md
Name: sar_search_8b

Overview:
- Successive-approximation search controller; the operand-driving end of the magnitude comparator interface.
- Drives a trial value onto comparator input a and samples the comparator's eq/lt/gt flags, one bit per cycle, MSB first.
- Recovers an unknown WIDTH-bit value held on comparator input b.
- Wraps the combinational 8-bit comparator to form a sequential value-discovery unit, e.g. for threshold search and comparator self-test.

Parameters:
- WIDTH, 8: width of the searched value and of guess/result.
- CNT_W, 4: width of the probe counter; 2^CNT_W must exceed WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  begin a search; sampled only in IDLE.
- guess  output  WIDTH  trial value driven to comparator input a.
- eq  input  1  comparator result: guess == target.
- lt  input  1  comparator result: guess < target.
- gt  input  1  comparator result: guess > target.
- busy  output  1  high while in PROBE.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  discovered value; held until the next accepted start.
- nprobes  output  CNT_W  number of probes used by the last search.
- err  output  1  sticky flag: an illegal flag combination was seen during the current or last search.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; trial, bitpos-derived guess, result, nprobes = 0; busy, done, err = 0. Reset takes effect at any point, including mid-PROBE, and abandons the search. No partial result is kept.
- States: IDLE, PROBE, DONE.
- IDLE:
  - guess=0, busy=0, done=0.
  - start=1 at an edge: trial<=0, bitpos<=WIDTH-1, nprobes<=0, err<=0, go to PROBE. result keeps its old value until DONE.
- PROBE:
  - busy=1.
  - guess = trial OR (1<<bitpos), combinational from the registers.
  - The comparator is combinational; its flags are sampled at the next edge.
  - Each edge in PROBE:
    - nprobes<=nprobes+1.
    - gt=1: bit stays 0.
    - Else (lt or eq): trial<=trial OR (1<<bitpos).
    - bitpos==0: go to DONE, result<=updated trial.
    - Otherwise: bitpos<=bitpos-1.
  - Flag priority when the combination is illegal: eq > gt > lt.
  - Illegal combination (not exactly one of eq/lt/gt high): err<=1, and the priority decision above is applied.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0, guess=result.
  - Always returns to IDLE. start is ignored in DONE.
- start while busy or in DONE: ignored; no restart, no queuing.
- Latency: start edge, then WIDTH probe edges, then done high for the cycle after the last probe edge (WIDTH+1 cycles after the start edge with WIDTH=8).
- Boundary values:
  - target 0: all probes gt, result=0.
  - target all-ones: all probes lt, result=2^WIDTH-1.
- nprobes and err hold after DONE until the next accepted start.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN.
- Defined: in PROBE, eq=1 sets the current bit, loads result with the updated trial and goes to DONE immediately, regardless of bitpos. The lower bits remain 0; nprobes reflects the shortened search.
- Undefined: eq is treated like lt for bit decisions. The search always runs exactly WIDTH probes and nprobes always ends at WIDTH.

Test Plan:
- Target 0xA5, feature off, start pulse:
  - guess sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - done pulse one cycle after the 8th probe edge.
  - result=0xA5, nprobes=8, err=0.
- Targets 0x00 and 0xFF, feature off:
  - result 0x00 and 0xFF respectively, 8 probes each, busy high for exactly 8 cycles.
- Target 0x80, feature on: first probe eq, done after 1 probe, result=0x80, nprobes=1.
- Target 0x3C, feature on: exits on eq at guess 0x3C, after 6 probes, nprobes=6.
- Illegal flags: force eq=lt=1 on the 3rd probe, target 0x55:
  - err=1 and stays high after done.
  - The eq-priority path is taken.
  - err clears at the next accepted start.
- Control robustness:
  - start re-asserted during PROBE and in DONE: ignored, and the sequence is unchanged.
  - rst_n=0 on the 4th probe: next cycle is IDLE with all outputs 0; a fresh start with target 0x5A yields result=0x5A.
